usb_rx_frontend: RTL and testbench
==================================

// Module: usb_rx_frontend
// PURPOSE
//  USB full-speed receive front end, directly upstream of the RX control unit.
//  - Synchronizes d_plus/d_minus and detects bus edges.
//  - Recovers bit timing, NRZI-decodes, removes stuffed bits and assembles bytes (LSB first).
//  - Flags EOP (SE0) and supplies d_edge/eop/shift_enable/rcv_data/byte_received to the RCU.
// PARAMETERS
//  CLKS_PER_BIT  8  clk cycles per USB bit time (min 4)
//  SAMPLE_POINT  3  timer count at which a bit is sampled (< CLKS_PER_BIT)
// PORTS
//  clk            in   1  system clock
//  n_rst          in   1  reset, asynchronous, active-low
//  d_plus         in   1  raw USB D+ (asynchronous)
//  d_minus        in   1  raw USB D- (asynchronous)
//  d_edge         out  1  one-clk pulse on any synchronized D+ transition
//  eop            out  1  level: SE0 seen at last sample point, while packet active
//  shift_enable   out  1  one-clk pulse at each bit sample point (incl. stuffed bits)
//  rcv_data       out  8  assembled byte; first-received bit in [0]
//  byte_received  out  1  one-clk pulse: rcv_data holds a complete byte
//  stuff_err      out  1  one-clk pulse: bit after six 1s was not 0
// BEHAVIOUR
//  Reset values: all outputs 0; rcv_data 8'h00; FSM IDLE; prev_dp 1 (J); ones count 0.
//  Sync: two flops each on d_plus/d_minus. dp_s/dm_s denote the synchronized values.
//    d_edge registered = dp_s ^ dp_s_q. Pulse appears 3 clks after a raw D+ change.
//  Timer: cnt 0..CLKS_PER_BIT-1, wraps. Forced to 0 in the cycle d_edge is high (resync).
//    shift_enable = 1 for the one clk where cnt==SAMPLE_POINT and FSM!=IDLE.
//  NRZI: at each sample, bit = (dp_s == prev_dp) ? 1 : 0; prev_dp <= dp_s.
//  Stuffing: ones counter increments on each decoded 1 and clears on a decoded 0.
//    The sample after ones==6 is the stuffed bit: it is not shifted and not counted.
//    Stuffed bit == 1 -> stuff_err pulse, FSM -> EOP_WAIT.
//  Shift: on a non-stuffed data bit, rcv_data <= {bit, rcv_data[7:1]}; bitcnt++.
//    On the 8th bit, byte_received pulses the next clk and bitcnt -> 0.
//    rcv_data is then stable until the next shift (>= CLKS_PER_BIT-1 clks).
//  Sync byte KJKJKJKK decodes to rcv_data == 8'h80.
//  FSM:
//    IDLE: on d_edge -> ACTIVE.
//      Actions on entry: cnt 0, bitcnt 0, ones 0, prev_dp 1, rcv_data kept.
//    ACTIVE: at a sample with dp_s==0 && dm_s==0 (SE0) -> EOP_WAIT.
//      Actions: eop <= 1; no shift; bitcnt/ones cleared; partial byte discarded, no byte_received.
//    EOP_WAIT: eop held 1 until a sample with J (dp_s=1, dm_s=0).
//      Then eop <= 0 and FSM -> IDLE.
//  Simultaneous events:
//    - d_edge at cnt==SAMPLE_POINT: resync wins, no sample that cycle.
//    - SE0 on the 8th bit slot: EOP wins, no byte_received.
//  Boundaries:
//    - Idle bus with no edges: no shift_enable.
//    - SE0 in IDLE is ignored.
//    - Stuff on the final bit of a byte is handled the same as any other stuffed bit.
//  Reset mid-packet: every register returns to its reset value immediately.
//    No pulses while n_rst is low.
// STRUCTURE
//  usb_pkg: SYNC_BYTE=8'h80, line-state enum {SE0,J,K,SE1}, FSM state enum, CLKS_PER_BIT default.
//  Sub-module rx_bit_timer: cnt, resync input, sample strobe output.
//  Sync, NRZI, destuff, shift and FSM logic live in this module.
// TESTING
//  1 Reset mid-packet: n_rst low during byte 2 -> all outputs 0 next clk.
//    After release: IDLE, no byte_received until a new sync.
//  2 Sync then PID 0xE1 (OUT), exact 8-clk bits:
//    byte_received twice; rcv_data 8'h80, then 8'hE1; first d_edge 3 clks after first K.
//  3 Data byte 0x3F followed by 0x01 (six 1s across the byte boundary):
//    the stuffed 0 is dropped; rcv_data 8'h3F, then 8'h01; stuff_err 0.
//  4 Seven consecutive 1s on the line: stuff_err pulses once.
//    FSM to EOP_WAIT; no further byte_received until IDLE.
//  5 SE0 for 2 bit times after 3 data bits, then J:
//    eop high from first SE0 sample to J sample; no byte_received; FSM IDLE.
//  6 Bit period jittered to 7 and 9 clks over a 3-byte packet:
//    resync keeps all samples mid-bit; bytes decoded correctly.

Source files
------------

// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - shared types and constants for the USB full-speed receive path
package usb_pkg;

    localparam int CLKS_PER_BIT_DEF = 8;
    localparam int SAMPLE_POINT_DEF = 3;
    localparam int MAX_ONES         = 6;
    localparam logic [7:0] SYNC_BYTE = 8'h80;

    // Line state encoded as {D+, D-}
    typedef enum logic [1:0] {
        LS_SE0 = 2'b00,
        LS_K   = 2'b01,
        LS_J   = 2'b10,
        LS_SE1 = 2'b11
    } line_state_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACTIVE   = 2'd1,
        ST_EOP_WAIT = 2'd2
    } rx_state_e;

    function automatic line_state_e line_state(input logic dp, input logic dm);
        return line_state_e'({dp, dm});
    endfunction

endpackage

// File: rtl/rx_bit_timer.sv
// rtl/rx_bit_timer.sv - free-running bit-time counter with edge resync and sample strobe
module rx_bit_timer #(
    parameter int CLKS_PER_BIT = 8,
    parameter int SAMPLE_POINT = 3
) (
    input  logic clk,
    input  logic n_rst,
    input  logic resync_i,
    output logic sample_o
);
    localparam int CW = $clog2(CLKS_PER_BIT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: a bus edge restarts the bit period, otherwise wrap at the bit length
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (resync_i) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
            cnt_d = '0;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A resync in the sample cycle suppresses the sample; the edge re-times the bit
    assign sample_o = !resync_i && (cnt_q == CW'(SAMPLE_POINT));

endmodule

// File: rtl/usb_rx_frontend.sv
// rtl/usb_rx_frontend.sv - USB FS receive front end: sync, NRZI decode, destuff, byte assembly, EOP
module usb_rx_frontend
    import usb_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int SAMPLE_POINT = SAMPLE_POINT_DEF
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       d_plus,
    input  logic       d_minus,
    output logic       d_edge,
    output logic       eop,
    output logic       shift_enable,
    output logic [7:0] rcv_data,
    output logic       byte_received,
    output logic       stuff_err
);
    logic        dp_meta_q;
    logic        dp_s_q;
    logic        dp_prev_q;
    logic        dm_meta_q;
    logic        dm_s_q;
    logic        d_edge_q;
    logic        sample;

    rx_state_e   state_q;
    logic        prev_dp_q;
    logic [2:0]  ones_q;
    logic [2:0]  bitcnt_q;
    logic [7:0]  rcv_data_q;
    logic        eop_q;
    logic        shift_enable_q;
    logic        byte_received_q;
    logic        stuff_err_q;

    line_state_e line;
    logic        rx_bit;

    // Two-flop synchronizers; D+ gets a third stage for edge detection (bus idles at J)
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            dp_meta_q <= 1'b1;
            dp_s_q    <= 1'b1;
            dp_prev_q <= 1'b1;
            dm_meta_q <= 1'b0;
            dm_s_q    <= 1'b0;
            d_edge_q  <= 1'b0;
        end else begin
            dp_meta_q <= d_plus;
            dp_s_q    <= dp_meta_q;
            dp_prev_q <= dp_s_q;
            dm_meta_q <= d_minus;
            dm_s_q    <= dm_meta_q;
            d_edge_q  <= dp_s_q ^ dp_prev_q;
        end
    end

    rx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .SAMPLE_POINT(SAMPLE_POINT)
    ) u_bit_timer (
        .clk      (clk),
        .n_rst    (n_rst),
        .resync_i (d_edge_q),
        .sample_o (sample)
    );

    assign line   = line_state(dp_s_q, dm_s_q);
    assign rx_bit = (dp_s_q == prev_dp_q);

    // Packet FSM: NRZI decode, bit destuffing, LSB-first byte assembly and EOP tracking
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q         <= ST_IDLE;
            prev_dp_q       <= 1'b1;
            ones_q          <= 3'd0;
            bitcnt_q        <= 3'd0;
            rcv_data_q      <= 8'h00;
            eop_q           <= 1'b0;
            shift_enable_q  <= 1'b0;
            byte_received_q <= 1'b0;
            stuff_err_q     <= 1'b0;
        end else begin
            byte_received_q <= 1'b0;
            stuff_err_q     <= 1'b0;
            shift_enable_q  <= sample && (state_q != ST_IDLE);
            case (state_q)
                ST_IDLE: begin
                    // Packets open with the J->K of SYNC; edges into SE0 or back to J are not starts
                    if (d_edge_q && line == LS_K) begin
                        state_q   <= ST_ACTIVE;
                        prev_dp_q <= 1'b1;
                        ones_q    <= 3'd0;
                        bitcnt_q  <= 3'd0;
                    end
                end
                ST_ACTIVE: begin
                    if (sample) begin
                        prev_dp_q <= dp_s_q;
                        if (line == LS_SE0) begin
                            eop_q    <= 1'b1;
                            state_q  <= ST_EOP_WAIT;
                            bitcnt_q <= 3'd0;
                            ones_q   <= 3'd0;
                        end else if (ones_q == 3'(MAX_ONES)) begin
                            // Stuffed slot: never shifted or counted, must decode as 0
                            ones_q <= 3'd0;
                            if (rx_bit) begin
                                stuff_err_q <= 1'b1;
                                state_q     <= ST_EOP_WAIT;
                                bitcnt_q    <= 3'd0;
                            end
                        end else begin
                            rcv_data_q <= {rx_bit, rcv_data_q[7:1]};
                            ones_q     <= rx_bit ? ones_q + 3'd1 : 3'd0;
                            bitcnt_q   <= bitcnt_q + 3'd1;
                            if (bitcnt_q == 3'd7) begin
                                byte_received_q <= 1'b1;
                            end
                        end
                    end
                end
                ST_EOP_WAIT: begin
                    if (sample) begin
                        prev_dp_q <= dp_s_q;
                        if (line == LS_J) begin
                            eop_q   <= 1'b0;
                            state_q <= ST_IDLE;
                        end else if (line == LS_SE0) begin
                            eop_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign d_edge        = d_edge_q;
    assign eop           = eop_q;
    assign shift_enable  = shift_enable_q;
    assign rcv_data      = rcv_data_q;
    assign byte_received = byte_received_q;
    assign stuff_err     = stuff_err_q;

endmodule

// File: tb/tb_usb_rx_frontend.sv
// tb/tb_usb_rx_frontend.sv - self-checking bench for usb_rx_frontend
module tb_usb_rx_frontend;
    import usb_pkg::*;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       d_plus;
    logic       d_minus;
    logic       d_edge;
    logic       eop;
    logic       shift_enable;
    logic [7:0] rcv_data;
    logic       byte_received;
    logic       stuff_err;

    usb_rx_frontend #(.CLKS_PER_BIT(8), .SAMPLE_POINT(3)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .d_plus        (d_plus),
        .d_minus       (d_minus),
        .d_edge        (d_edge),
        .eop           (eop),
        .shift_enable  (shift_enable),
        .rcv_data      (rcv_data),
        .byte_received (byte_received),
        .stuff_err     (stuff_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Observed event log, sampled on the falling edge
    logic [7:0] got_q[$];
    int n_stuff    = 0;
    int n_eop      = 0;
    int n_eop_clks = 0;
    int n_shift    = 0;
    int n_dedge    = 0;
    logic eop_prev = 1'b0;

    always @(negedge clk) begin
        if (byte_received) got_q.push_back(rcv_data);
        n_stuff    <= n_stuff + int'(stuff_err);
        n_eop      <= n_eop + int'(eop && !eop_prev);
        n_eop_clks <= n_eop_clks + int'(eop);
        n_shift    <= n_shift + int'(shift_enable);
        n_dedge    <= n_dedge + int'(d_edge);
        eop_prev   <= eop;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Transmit side: one line symbol per bit time
    line_state_e syms[$];
    logic tx_level;
    int   tx_ones;

    task automatic emit(input logic v);
        if (!v) tx_level = ~tx_level;
        syms.push_back(tx_level ? LS_J : LS_K);
    endtask

    task automatic add_bits(input logic [7:0] b, input int n, input bit stuff);
        for (int i = 0; i < n; i++) begin
            emit(b[i]);
            if (stuff) begin
                if (b[i]) tx_ones++;
                else tx_ones = 0;
                if (tx_ones == 6) begin
                    emit(1'b0);
                    tx_ones = 0;
                end
            end
        end
    endtask

    task automatic start_packet();
        syms.delete();
        tx_level = 1'b1;
        tx_ones  = 0;
        add_bits(SYNC_BYTE, 8, 1'b1);
    endtask

    task automatic end_packet();
        syms.push_back(LS_SE0);
        syms.push_back(LS_SE0);
        syms.push_back(LS_J);
    endtask

    task automatic play(input int jitter, input int limit, output int lat);
        logic [1:0] v;
        int dur;
        lat = -1;
        for (int i = 0; i < limit && i < syms.size(); i++) begin
            v = syms[i];
            {d_plus, d_minus} = v;
            dur = (jitter != 0) ? (((i % 2) != 0) ? 9 : 7) : 8;
            for (int c = 0; c < dur; c++) begin
                @(negedge clk);
                if (i == 0 && lat < 0 && d_edge) lat = c + 1;
            end
        end
    endtask

    task automatic idle(input int n);
        d_plus  = 1'b1;
        d_minus = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Reference: walks the symbol list one bit time at a time using the receive rules
    logic [7:0] mdl_bytes[$];
    int mdl_stuff;
    int mdl_eop;

    function automatic void model_run();
        int st = 0;
        logic prev = 1'b1;
        logic last_dp = 1'b1;
        logic eopl = 1'b0;
        logic dp, b;
        int ones = 0;
        int nb = 0;
        logic [7:0] sh = 8'h00;
        mdl_bytes.delete();
        mdl_stuff = 0;
        mdl_eop   = 0;
        foreach (syms[i]) begin
            dp = (syms[i] == LS_J) || (syms[i] == LS_SE1);
            if (st == 0 && syms[i] == LS_K && last_dp) begin
                st = 1; prev = 1'b1; ones = 0; nb = 0;
            end
            last_dp = dp;
            if (st == 1) begin
                if (syms[i] == LS_SE0) begin
                    if (!eopl) mdl_eop++;
                    eopl = 1'b1; st = 2; nb = 0; ones = 0;
                end else begin
                    b = (dp == prev);
                    prev = dp;
                    if (ones == 6) begin
                        ones = 0;
                        if (b) begin
                            mdl_stuff++; st = 2; nb = 0;
                        end
                    end else begin
                        sh = {b, sh[7:1]};
                        ones = b ? ones + 1 : 0;
                        nb++;
                        if (nb == 8) begin
                            mdl_bytes.push_back(sh);
                            nb = 0;
                        end
                    end
                end
            end else if (st == 2) begin
                prev = dp;
                if (syms[i] == LS_J) begin
                    eopl = 1'b0; st = 0;
                end else if (syms[i] == LS_SE0) begin
                    if (!eopl) mdl_eop++;
                    eopl = 1'b1;
                end
            end
        end
    endfunction

    typedef struct {
        int          nbytes;
        logic [23:0] d;
        int          part;
        logic [7:0]  pb;
        int          raw_ones;
        int          jitter;
        int          exp_n;
        logic [31:0] e;
        int          exp_stuff;
        int          exp_eop;
        int          exp_eop_clks;
    } vec_t;

    vec_t tbl[6];

    int b0, s0, e0, ec0, sh0, de0, lat;

    initial begin
        tbl[0] = '{nbytes:1, d:24'h0000E1, part:0, pb:8'h00, raw_ones:0,  jitter:0, exp_n:2, e:32'h0000E180, exp_stuff:0, exp_eop:1, exp_eop_clks:16};
        tbl[1] = '{nbytes:2, d:24'h00013F, part:0, pb:8'h00, raw_ones:0,  jitter:0, exp_n:3, e:32'h00013F80, exp_stuff:0, exp_eop:1, exp_eop_clks:16};
        tbl[2] = '{nbytes:0, d:24'h000000, part:0, pb:8'h00, raw_ones:14, jitter:0, exp_n:1, e:32'h00000080, exp_stuff:1, exp_eop:1, exp_eop_clks:16};
        tbl[3] = '{nbytes:0, d:24'h000000, part:3, pb:8'h05, raw_ones:0,  jitter:0, exp_n:1, e:32'h00000080, exp_stuff:0, exp_eop:1, exp_eop_clks:16};
        tbl[4] = '{nbytes:3, d:24'h00FFA5, part:0, pb:8'h00, raw_ones:0,  jitter:1, exp_n:4, e:32'h00FFA580, exp_stuff:0, exp_eop:1, exp_eop_clks:0};
        tbl[5] = '{nbytes:2, d:24'h0012FC, part:0, pb:8'h00, raw_ones:0,  jitter:0, exp_n:3, e:32'h0012FC80, exp_stuff:0, exp_eop:1, exp_eop_clks:16};

        n_rst   = 1'b0;
        d_plus  = 1'b1;
        d_minus = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'({d_edge, eop, shift_enable, byte_received, stuff_err, rcv_data}), 0);
        n_rst = 1'b1;
        idle(40);
        chk("idle_no_shift", n_shift, 0);
        chk("idle_no_edge", n_dedge, 0);

        // Reset asserted part way into the second byte
        start_packet();
        add_bits(8'hE1, 8, 1'b1);
        add_bits(8'h3C, 8, 1'b1);
        end_packet();
        b0 = got_q.size();
        play(0, 12, lat);
        chk("rst_sync_before", got_q.size() - b0, 1);
        n_rst = 1'b0;
        #1;
        chk("rst_outputs_zero", int'({d_edge, eop, shift_enable, byte_received, stuff_err, rcv_data}), 0);
        b0 = got_q.size(); sh0 = n_shift; de0 = n_dedge;
        for (int k = 0; k < 3; k++) begin
            d_plus = 1'b0; d_minus = 1'b1;
            repeat (8) @(negedge clk);
            d_plus = 1'b1; d_minus = 1'b0;
            repeat (8) @(negedge clk);
        end
        chk("rst_no_edge", n_dedge - de0, 0);
        chk("rst_no_shift", n_shift - sh0, 0);
        n_rst = 1'b1;
        idle(48);
        chk("rst_after_no_byte", got_q.size() - b0, 0);
        chk("rst_after_no_shift", n_shift - sh0, 0);

        // Table-driven packets
        for (int r = 0; r < 6; r++) begin
            start_packet();
            for (int j = 0; j < tbl[r].nbytes; j++) add_bits(tbl[r].d[8*j +: 8], 8, 1'b1);
            if (tbl[r].part > 0) add_bits(tbl[r].pb, tbl[r].part, 1'b1);
            for (int j = 0; j < tbl[r].raw_ones; j++) add_bits(8'h01, 1, 1'b0);
            end_packet();
            b0 = got_q.size(); s0 = n_stuff; e0 = n_eop; ec0 = n_eop_clks;
            play(tbl[r].jitter, syms.size(), lat);
            idle(24);
            chk($sformatf("row%0d_edge_latency", r), lat, 3);
            chk($sformatf("row%0d_nbytes", r), got_q.size() - b0, tbl[r].exp_n);
            for (int j = 0; j < tbl[r].exp_n; j++) begin
                if (b0 + j < got_q.size())
                    chk($sformatf("row%0d_byte%0d", r, j), int'(got_q[b0 + j]), int'(tbl[r].e[8*j +: 8]));
            end
            chk($sformatf("row%0d_stuff_err", r), n_stuff - s0, tbl[r].exp_stuff);
            chk($sformatf("row%0d_eop_count", r), n_eop - e0, tbl[r].exp_eop);
            if (tbl[r].exp_eop_clks != 0)
                chk($sformatf("row%0d_eop_clks", r), n_eop_clks - ec0, tbl[r].exp_eop_clks);
            chk($sformatf("row%0d_eop_final", r), int'(eop), 0);
        end

        // Randomized packets and raw bit streams against the reference
        for (int r = 0; r < 10; r++) begin
            int jit;
            start_packet();
            if (r < 5) begin
                jit = int'($urandom_range(0, 1));
                for (int j = 0; j < int'($urandom_range(1, 3)); j++)
                    add_bits(8'($urandom_range(0, 255)), 8, 1'b1);
            end else begin
                jit = 0;
                for (int j = 0; j < 24; j++)
                    add_bits(($urandom_range(0, 99) < 75) ? 8'h01 : 8'h00, 1, 1'b0);
            end
            end_packet();
            model_run();
            b0 = got_q.size(); s0 = n_stuff; e0 = n_eop;
            play(jit, syms.size(), lat);
            idle(24);
            chk($sformatf("rnd%0d_nbytes", r), got_q.size() - b0, mdl_bytes.size());
            for (int j = 0; j < mdl_bytes.size(); j++) begin
                if (b0 + j < got_q.size())
                    chk($sformatf("rnd%0d_byte%0d", r, j), int'(got_q[b0 + j]), int'(mdl_bytes[j]));
            end
            chk($sformatf("rnd%0d_stuff_err", r), n_stuff - s0, mdl_stuff);
            chk($sformatf("rnd%0d_eop_count", r), n_eop - e0, mdl_eop);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
